// File: rtl/pc_lut_loader_if.sv
// Write-stream handshake for the branch-target table loader.
// One beat per cycle when wr_valid and wr_ready are both high.
interface pc_lut_loader_if #(
   parameter int D = 12
);
   logic         wr_valid;
   logic [D-1:0] wr_data;
   logic         wr_last;
   logic         wr_ready;

   modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
   modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/pc_lut_loader.sv
// Writable branch-target table with a streaming load engine and a registered read port.
// Each load session clears the table and fills it from index 0 upward.
module pc_lut_loader #(
   parameter int D       = 12,
   parameter int ENTRIES = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   pc_lut_loader_if.slave  wr,
   output logic            busy,
   output logic            done,
   output logic [8:0]      count,
   input  logic [7:0]      rd_addr,
   output logic [D-1:0]    rd_target
);
   localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] idx;
   logic [D-1:0]  lut [ENTRIES];
   logic          accept;
   logic          enter_load;
   logic          last_beat;
   logic          rd_hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Handshake outputs decode from state only; wr_valid/start only steer the next state.
   always_comb begin
      state_nxt   = state;
      wr.wr_ready = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      accept      = 1'b0;
      enter_load  = 1'b0;
      last_beat   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt  = LOAD;
               enter_load = 1'b1;
            end
         end
         LOAD: begin
            wr.wr_ready = 1'b1;
            busy        = 1'b1;
            accept      = wr.wr_valid;
            last_beat   = wr.wr_last || (idx == IW'(ENTRIES - 1));
            if (accept && last_beat) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_nxt  = LOAD;
               enter_load = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_hit = ({1'b0, rd_addr} < 9'(ENTRIES));

   // Read samples the pre-update table, so same-edge writes and clears show up one edge later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx       <= '0;
         count     <= '0;
         rd_target <= '0;
         for (int i = 0; i < ENTRIES; i++) lut[i] <= '0;
      end else begin
         rd_target <= rd_hit ? lut[rd_addr[IW-1:0]] : '0;
         if (enter_load) begin
            idx   <= '0;
            count <= '0;
            for (int i = 0; i < ENTRIES; i++) lut[i] <= '0;
         end else if (accept) begin
            lut[idx] <= wr.wr_data;
            idx      <= idx + 1'b1;
            count    <= count + 9'd1;
         end
      end
   end
endmodule

// File: tb/tb_pc_lut_loader.sv
// Directed bench for pc_lut_loader: reset, full/short loads, reload clearing,
// read/write collision and reset in the middle of a session.
module tb_pc_lut_loader;
   localparam int D       = 12;
   localparam int ENTRIES = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic          busy;
   logic          done;
   logic [8:0]    count;
   logic [7:0]    rd_addr;
   logic [D-1:0]  rd_target;

   int n_cmp = 0;
   int n_err = 0;

   pc_lut_loader_if #(.D(D)) bus ();

   pc_lut_loader #(.D(D), .ENTRIES(ENTRIES)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .wr        (bus),
      .busy      (busy),
      .done      (done),
      .count     (count),
      .rd_addr   (rd_addr),
      .rd_target (rd_target)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input int addr, input logic [31:0] exp, input string tag);
      rd_addr = 8'(addr);
      step();
      chk($sformatf("%s[%0d]", tag, addr), 32'(rd_target), exp);
   endtask

   task automatic beat(input logic [D-1:0] data, input logic last);
      bus.wr_valid = 1'b1;
      bus.wr_data  = data;
      bus.wr_last  = last;
      step();
      bus.wr_valid = 1'b0;
      bus.wr_last  = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   logic [D-1:0] short_v [5];

   initial begin
      short_v[0] = 12'hABC; short_v[1] = 12'h001; short_v[2] = 12'hFFF;
      short_v[3] = 12'h123; short_v[4] = 12'h456;
      reset_n      = 1'b1;
      start        = 1'b0;
      rd_addr      = 8'd0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.wr_last  = 1'b0;
      step();

      // Asynchronous reset mid-cycle
      #2 reset_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ready", 32'(bus.wr_ready), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_rd", 32'(rd_target), 0);
      step();
      step();
      reset_n = 1'b1;
      for (int i = 0; i < ENTRIES; i++) rd(i, 0, "rst_tab");

      // Full load, wr_last never asserted
      do_start();
      chk("fl_ready", 32'(bus.wr_ready), 1);
      chk("fl_busy", 32'(busy), 1);
      chk("fl_count0", 32'(count), 0);
      bus.wr_valid = 1'b1;
      for (int i = 0; i < ENTRIES; i++) begin
         bus.wr_data = 12'(i * 3 + 12'h100);
         step();
         if (i == ENTRIES - 2) chk("fl_busy31", 32'(busy), 1);
      end
      bus.wr_valid = 1'b0;
      chk("fl_done", 32'(done), 1);
      chk("fl_ready_end", 32'(bus.wr_ready), 0);
      chk("fl_busy_end", 32'(busy), 0);
      chk("fl_count", 32'(count), 32);
      for (int i = 0; i < ENTRIES; i++) rd(i, 32'(i * 3 + 12'h100), "fl_tab");
      rd(40, 0, "fl_oob");

      // Reload clears; a start pulse inside LOAD is ignored
      do_start();
      chk("rl_count0", 32'(count), 0);
      beat(12'h007, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("rl_count_after_start", 32'(count), 1);
      beat(12'h008, 1'b1);
      chk("rl_done", 32'(done), 1);
      chk("rl_count", 32'(count), 2);
      rd(0, 12'h007, "rl_tab");
      rd(1, 12'h008, "rl_tab");
      for (int i = 2; i < ENTRIES; i++) rd(i, 0, "rl_tab");

      // Short load with wr_valid toggling; idle beats carry junk data
      do_start();
      for (int k = 0; k < 5; k++) begin
         bus.wr_data = 12'h555;
         step();
         beat(short_v[k], k == 4);
      end
      chk("sh_done", 32'(done), 1);
      chk("sh_count", 32'(count), 5);
      for (int i = 0; i < 5; i++) rd(i, 32'(short_v[i]), "sh_tab");
      rd(5, 0, "sh_tab");
      rd(6, 0, "sh_tab");

      // Read/write collision on the index being written
      do_start();
      rd_addr = 8'd0;
      beat(12'h321, 1'b0);
      chk("col0_old", 32'(rd_target), 0);
      step();
      chk("col0_new", 32'(rd_target), 12'h321);
      rd_addr = 8'd1;
      beat(12'h654, 1'b1);
      chk("col1_old", 32'(rd_target), 0);
      step();
      chk("col1_new", 32'(rd_target), 12'h654);
      chk("col_done", 32'(done), 1);

      // Start and clear on the same edge: read captures pre-clear content
      rd_addr = 8'd0;
      do_start();
      chk("clr_pre", 32'(rd_target), 12'h321);
      step();
      chk("clr_post", 32'(rd_target), 0);

      // Reset in the middle of a session
      beat(12'h00A, 1'b0);
      beat(12'h00B, 1'b0);
      beat(12'h00C, 1'b0);
      chk("mr_count3", 32'(count), 3);
      chk("mr_busy3", 32'(busy), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mr_busy", 32'(busy), 0);
      chk("mr_ready", 32'(bus.wr_ready), 0);
      chk("mr_count", 32'(count), 0);
      step();
      reset_n = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 12'hEEE;
      step();
      step();
      bus.wr_valid = 1'b0;
      chk("mr_idle_ready", 32'(bus.wr_ready), 0);
      chk("mr_idle_done", 32'(done), 0);
      chk("mr_idle_count", 32'(count), 0);
      for (int i = 0; i < 4; i++) rd(i, 0, "mr_tab");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
